fft_stage_ctrl: RTL and testbench

FFT_STAGE_CTRL -- requirements
Module: fft_stage_ctrl

---
 rtl/fft_stage_ctrl_if.sv | 31 +++
 rtl/fft_stage_ctrl.sv | 126 ++++++++++++
 tb/tb_fft_stage_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fft_stage_ctrl_if.sv
// Handshake and control bundle between the FFT stage controller and its datapath/source.
// The master side supplies input blocks; the slave side is the controller.
interface fft_stage_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             din_valid;
    logic             din_sof;
    logic             din_ready;
    logic             buf_shift_en;
    logic             buf_sel;
    logic             bfly_en;
    logic [CNT_W-1:0] tw_idx;
    logic             dout_valid;
    logic             dout_sel;
    logic             dout_eof;
    logic             busy;
    logic             sof_err;
    logic [15:0]      frame_cnt;

    modport master (
        output din_valid, din_sof,
        input  din_ready, buf_shift_en, buf_sel, bfly_en, tw_idx,
               dout_valid, dout_sel, dout_eof, busy, sof_err, frame_cnt
    );

    modport slave (
        input  din_valid, din_sof,
        output din_ready, buf_shift_en, buf_sel, bfly_en, tw_idx,
               dout_valid, dout_sel, dout_eof, busy, sof_err, frame_cnt
    );
endinterface

// File: rtl/fft_stage_ctrl.sv
// Radix-2 SDF FFT stage controller: fills the delay buffer for half a frame, runs the
// butterfly on the second half, then drains the buffered differences.
module fft_stage_ctrl #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rstn,
    fft_stage_ctrl_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, FILL, BFLY, DRAIN} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sof_err_q;
    logic [15:0]      frame_cnt_q;

    logic             din_ready;
    logic             accept;
    logic             last;
    logic             buf_shift_en;
    logic             buf_sel;
    logic             bfly_en;
    logic [CNT_W-1:0] tw_idx;
    logic             dout_valid;
    logic             dout_sel;
    logic             dout_eof;

    assign din_ready = (state != DRAIN);
    assign accept    = bus.din_valid && din_ready;
    assign last      = (cnt == LAST);

    // Control is decoded straight from state/cnt/din_valid so the datapath sees it in the accept cycle.
    always_comb begin
        buf_shift_en = 1'b0;
        buf_sel      = 1'b0;
        bfly_en      = 1'b0;
        tw_idx       = '0;
        dout_valid   = 1'b0;
        dout_sel     = 1'b0;
        dout_eof     = 1'b0;
        unique case (state)
            IDLE:  buf_shift_en = accept && bus.din_sof;
            FILL:  buf_shift_en = accept;
            BFLY: begin
                buf_shift_en = accept;
                // a sof here restarts the frame, so the block is buffered rather than butterflied
                if (accept && !bus.din_sof) begin
                    bfly_en    = 1'b1;
                    buf_sel    = 1'b1;
                    dout_valid = 1'b1;
                    tw_idx     = cnt;
                end
            end
            DRAIN: begin
                buf_shift_en = 1'b1;
                dout_valid   = 1'b1;
                dout_sel     = 1'b1;
                tw_idx       = cnt;
                dout_eof     = last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            cnt         <= '0;
            sof_err_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            sof_err_q <= 1'b0;
            unique case (state)
                IDLE: if (accept) begin
                    if (bus.din_sof) begin
                        state <= FILL;
                        cnt   <= ONE;
                    end else begin
                        sof_err_q <= 1'b1;
                    end
                end
                FILL, BFLY: if (accept) begin
                    if (bus.din_sof) begin
                        state     <= FILL;
                        cnt       <= ONE;
                        sof_err_q <= 1'b1;
                    end else if (last) begin
                        state <= (state == FILL) ? BFLY : DRAIN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                DRAIN: begin
                    if (last) begin
                        state <= IDLE;
                        cnt   <= '0;
                        if (frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.din_ready    = din_ready;
    assign bus.buf_shift_en = buf_shift_en;
    assign bus.buf_sel      = buf_sel;
    assign bus.bfly_en      = bfly_en;
    assign bus.tw_idx       = tw_idx;
    assign bus.dout_valid   = dout_valid;
    assign bus.dout_sel     = dout_sel;
    assign bus.dout_eof     = dout_eof;
    assign bus.busy         = (state != IDLE);
    assign bus.sof_err      = sof_err_q;
    assign bus.frame_cnt    = frame_cnt_q;
endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Scoreboard bench for fft_stage_ctrl at DEPTH=4: the driver queues expected output blocks
// and error pulses, and a negedge monitor pops and compares them as the DUT presents them.
module tb_fft_stage_ctrl;
    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    typedef struct packed {
        logic [31:0]      cyc;
        logic [CNT_W-1:0] tw;
        logic             sel;
        logic             eof;
        logic             bf;
        logic             bs;
        logic             sh;
    } out_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cyc_n = 0;
    int   checks = 0;
    int   passes = 0;
    out_t oq[$];
    int   eq[$];

    fft_stage_ctrl_if #(.CNT_W(CNT_W)) bus();

    fft_stage_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    endtask

    // monitor: every presented output block / error pulse must match the queued expectation
    always @(negedge clk) begin
        if (bus.dout_valid === 1'b1) begin
            out_t a;
            a = '{cyc: 32'(cyc_n), tw: bus.tw_idx, sel: bus.dout_sel, eof: bus.dout_eof,
                  bf: bus.bfly_en, bs: bus.buf_sel, sh: bus.buf_shift_en};
            if (oq.size() == 0) chk("unexpected_dout", 32'(a.cyc), 32'hFFFFFFFF);
            else begin
                out_t e;
                e = oq.pop_front();
                chk("dout_block", 32'(a), 32'(e));
            end
        end
        if (bus.sof_err === 1'b1) begin
            if (eq.size() == 0) chk("unexpected_sof_err", 32'(cyc_n), 32'hFFFFFFFF);
            else chk("sof_err_cycle", 32'(cyc_n), 32'(eq.pop_front()));
        end
    end

    task automatic drive(input bit v, input bit s);
        @(posedge clk);
        #1;
        bus.din_valid = v;
        bus.din_sof   = s;
    endtask

    task automatic exp_out(input int tw, input bit sel, input bit eof, input bit bf, input bit bs);
        oq.push_back('{cyc: 32'(cyc_n), tw: CNT_W'(tw), sel: sel, eof: eof, bf: bf, bs: bs, sh: 1'b1});
    endtask

    task automatic idle_gap();
        drive(1'b0, 1'b0);
        #1;
        chk("gap_shift", 32'(bus.buf_shift_en), 32'd0);
        chk("gap_tw",    32'(bus.tw_idx),       32'd0);
    endtask

    task automatic sof_block();
        drive(1'b1, 1'b1);
        #1;
        chk("sof_shift", 32'(bus.buf_shift_en), 32'd1);
        chk("sof_bsel",  32'(bus.buf_sel),      32'd0);
    endtask

    task automatic fill(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            if (gap) idle_gap();
            drive(1'b1, 1'b0);
            #1;
            chk("fill_shift", 32'(bus.buf_shift_en), 32'd1);
            chk("fill_bfly",  32'(bus.bfly_en),      32'd0);
        end
    endtask

    task automatic bfly(input int from, input int n, input bit gap);
        for (int i = from; i < from + n; i++) begin
            if (gap) idle_gap();
            drive(1'b1, 1'b0);
            exp_out(i, 1'b0, 1'b0, 1'b1, 1'b1);
        end
    endtask

    task automatic drain(input int n, input bit hold);
        for (int i = 0; i < n; i++) begin
            drive(hold, hold && (i == 0));
            exp_out(i, 1'b1, i == DEPTH - 1, 1'b0, 1'b0);
            #1;
            chk("drain_ready", 32'(bus.din_ready), 32'd0);
        end
    endtask

    task automatic run_frame(input bit gap, input bit hold);
        sof_block();
        fill(DEPTH - 1, gap);
        bfly(0, DEPTH, gap);
        drain(DEPTH, hold);
    endtask

    task automatic expect_idle(input int fc);
        drive(1'b0, 1'b0);
        #1;
        chk("frame_cnt", 32'(bus.frame_cnt), 32'(fc));
        chk("idle_busy", 32'(bus.busy),      32'd0);
        chk("idle_ready",32'(bus.din_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.din_valid = 1'b0;
        bus.din_sof   = 1'b0;
        #12;
        chk("rst_ready",   32'(bus.din_ready),    32'd1);
        chk("rst_busy",    32'(bus.busy),         32'd0);
        chk("rst_dout",    32'(bus.dout_valid),   32'd0);
        chk("rst_shift",   32'(bus.buf_shift_en), 32'd0);
        chk("rst_sof_err", 32'(bus.sof_err),      32'd0);
        chk("rst_fcnt",    32'(bus.frame_cnt),    32'd0);
        @(negedge clk) rstn = 1'b1;

        // continuous frame
        run_frame(1'b0, 1'b0);
        expect_idle(1);

        // same frame with a bubble before every block
        run_frame(1'b1, 1'b0);
        expect_idle(2);

        // block without sof while idle is dropped with an error pulse
        drive(1'b1, 1'b0);
        eq.push_back(cyc_n + 1);
        #1;
        chk("nosof_shift", 32'(bus.buf_shift_en), 32'd0);
        expect_idle(2);

        // sof at butterfly block 2 restarts the frame
        sof_block();
        fill(DEPTH - 1, 1'b0);
        bfly(0, 2, 1'b0);
        drive(1'b1, 1'b1);
        eq.push_back(cyc_n + 1);
        #1;
        chk("abort_bfly",  32'(bus.bfly_en),      32'd0);
        chk("abort_bsel",  32'(bus.buf_sel),      32'd0);
        chk("abort_shift", 32'(bus.buf_shift_en), 32'd1);
        chk("abort_fcnt",  32'(bus.frame_cnt),    32'd2);
        fill(DEPTH - 1, 1'b0);
        bfly(0, DEPTH, 1'b0);
        drain(DEPTH, 1'b0);
        expect_idle(3);

        // din_valid (and a stray sof) held through drain is ignored; next sof starts at once
        run_frame(1'b0, 1'b1);
        run_frame(1'b0, 1'b0);
        expect_idle(5);

        // reset during drain at cnt=2
        sof_block();
        fill(DEPTH - 1, 1'b0);
        bfly(0, DEPTH, 1'b0);
        drain(2, 1'b0);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        bus.din_valid = 1'b0;
        #1;
        chk("rstmid_ready", 32'(bus.din_ready),  32'd1);
        chk("rstmid_dout",  32'(bus.dout_valid), 32'd0);
        chk("rstmid_fcnt",  32'(bus.frame_cnt),  32'd0);
        chk("rstmid_busy",  32'(bus.busy),       32'd0);
        @(negedge clk) rstn = 1'b1;

        // first post-reset frame still needs sof
        drive(1'b1, 1'b0);
        eq.push_back(cyc_n + 1);
        run_frame(1'b0, 1'b0);
        expect_idle(1);
        expect_idle(1);

        chk("outq_empty", 32'(oq.size()), 32'd0);
        chk("errq_empty", 32'(eq.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
